// File: rtl/accelerator_integer_adder_arbiter.sv
// Round-robin arbiter sharing one scalar integer adder among REQUESTERS clients.
// Define ACCELERATOR_ADDER_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins arbitration.

module accelerator_integer_adder_arbiter_pending (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  input  logic clr,
  output logic pending
);
  // Set wins over clear so a client can re-arm in its own completion cycle.
  always_ff @(posedge CLK or posedge RST)
    if (RST) pending <= 1'b0;
    else     pending <= start | (pending & ~clr);
endmodule

module accelerator_integer_adder_arbiter #(
  parameter int DATA_SIZE  = 64,
  parameter int REQUESTERS = 4,
  parameter int INDEX_SIZE = 2
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [REQUESTERS-1:0]                REQ_START,
  input  logic [REQUESTERS-1:0]                REQ_OPERATION,
  input  logic [REQUESTERS-1:0][DATA_SIZE-1:0] REQ_DATA_A_IN,
  input  logic [REQUESTERS-1:0][DATA_SIZE-1:0] REQ_DATA_B_IN,
  output logic [REQUESTERS-1:0]                REQ_READY,
  output logic [DATA_SIZE-1:0]                 REQ_DATA_OUT,
  output logic                                 REQ_OVERFLOW_OUT,
  output logic [INDEX_SIZE-1:0]                GRANT_INDEX,
  output logic                                 BUSY,
  output logic                                 ADDER_START,
  input  logic                                 ADDER_READY,
  output logic                                 ADDER_OPERATION,
  output logic [DATA_SIZE-1:0]                 ADDER_DATA_A_IN,
  output logic [DATA_SIZE-1:0]                 ADDER_DATA_B_IN,
  input  logic [DATA_SIZE-1:0]                 ADDER_DATA_OUT,
  input  logic                                 ADDER_OVERFLOW_OUT
);

  typedef enum logic [1:0] {
    IDLE_STATE = 2'd0,
    WAIT_STATE = 2'd1
  } state_t;

  state_t                  state, state_nxt;
  logic [REQUESTERS-1:0]   pending, clr, done_onehot;
  logic [INDEX_SIZE-1:0]   grant;
  logic                    grant_vld, grant_fire, done_fire;

  assign done_onehot = REQUESTERS'(1) << GRANT_INDEX;
  assign clr         = done_fire ? done_onehot : '0;

  generate
    for (genvar i = 0; i < REQUESTERS; i++) begin : g_lane
      accelerator_integer_adder_arbiter_pending u_pend (
        .CLK     (CLK),
        .RST     (RST),
        .start   (REQ_START[i]),
        .clr     (clr[i]),
        .pending (pending[i])
      );
    end
  endgenerate

`ifdef ACCELERATOR_ADDER_ARBITER_FIXED_PRIORITY_EN
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      if (pending[INDEX_SIZE'(i)]) begin
        grant     = INDEX_SIZE'(i);
        grant_vld = 1'b1;
      end
    end
  end
`else
  logic [INDEX_SIZE-1:0] rr_ptr;

  // Scan from farthest to nearest so the first pending index after rr_ptr lands last.
  always_comb begin
    logic [INDEX_SIZE-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = REQUESTERS; k >= 1; k--) begin
      idx = INDEX_SIZE'((int'(rr_ptr) + k) % REQUESTERS);
      if (pending[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST)            rr_ptr <= INDEX_SIZE'(REQUESTERS - 1);
    else if (done_fire) rr_ptr <= GRANT_INDEX;
`endif

  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE_STATE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    done_fire  = 1'b0;
    case (state)
      IDLE_STATE: if (grant_vld) begin
        grant_fire = 1'b1;
        state_nxt  = WAIT_STATE;
      end
      WAIT_STATE: if (ADDER_READY) begin
        done_fire = 1'b1;
        state_nxt = IDLE_STATE;
      end
      default: state_nxt = IDLE_STATE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      REQ_READY        <= '0;
      REQ_DATA_OUT     <= '0;
      REQ_OVERFLOW_OUT <= 1'b0;
      GRANT_INDEX      <= '0;
      BUSY             <= 1'b0;
      ADDER_START      <= 1'b0;
      ADDER_OPERATION  <= 1'b0;
      ADDER_DATA_A_IN  <= '0;
      ADDER_DATA_B_IN  <= '0;
    end else begin
      ADDER_START <= grant_fire;
      REQ_READY   <= done_fire ? done_onehot : '0;
      // Operands are sampled once at grant; the client holds them while pending.
      if (grant_fire) begin
        GRANT_INDEX     <= grant;
        ADDER_OPERATION <= REQ_OPERATION[grant];
        ADDER_DATA_A_IN <= REQ_DATA_A_IN[grant];
        ADDER_DATA_B_IN <= REQ_DATA_B_IN[grant];
        BUSY            <= 1'b1;
      end
      if (done_fire) begin
        REQ_DATA_OUT     <= ADDER_DATA_OUT;
        REQ_OVERFLOW_OUT <= ADDER_OVERFLOW_OUT;
        BUSY             <= 1'b0;
      end
    end

endmodule

// File: tb/tb_accelerator_integer_adder_arbiter.sv
// Directed bench for accelerator_integer_adder_arbiter with a 3-cycle adder model.
module tb_accelerator_integer_adder_arbiter;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [3:0]       REQ_START = '0;
  logic [3:0]       REQ_OPERATION = '0;
  logic [3:0][63:0] REQ_DATA_A_IN = '0;
  logic [3:0][63:0] REQ_DATA_B_IN = '0;
  logic [3:0]       REQ_READY;
  logic [63:0]      REQ_DATA_OUT;
  logic             REQ_OVERFLOW_OUT;
  logic [1:0]       GRANT_INDEX;
  logic             BUSY, ADDER_START, ADDER_READY, ADDER_OPERATION;
  logic [63:0]      ADDER_DATA_A_IN, ADDER_DATA_B_IN, ADDER_DATA_OUT;
  logic             ADDER_OVERFLOW_OUT;

  always #5 CLK = ~CLK;

  accelerator_integer_adder_arbiter #(.DATA_SIZE(64), .REQUESTERS(4), .INDEX_SIZE(2)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_START(REQ_START), .REQ_OPERATION(REQ_OPERATION),
    .REQ_DATA_A_IN(REQ_DATA_A_IN), .REQ_DATA_B_IN(REQ_DATA_B_IN),
    .REQ_READY(REQ_READY), .REQ_DATA_OUT(REQ_DATA_OUT), .REQ_OVERFLOW_OUT(REQ_OVERFLOW_OUT),
    .GRANT_INDEX(GRANT_INDEX), .BUSY(BUSY),
    .ADDER_START(ADDER_START), .ADDER_READY(ADDER_READY), .ADDER_OPERATION(ADDER_OPERATION),
    .ADDER_DATA_A_IN(ADDER_DATA_A_IN), .ADDER_DATA_B_IN(ADDER_DATA_B_IN),
    .ADDER_DATA_OUT(ADDER_DATA_OUT), .ADDER_OVERFLOW_OUT(ADDER_OVERFLOW_OUT)
  );

  // Shared adder stand-in: result and READY three cycles after START is sampled.
  function automatic logic ovf_f(input logic op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    r = op ? a - b : a + b;
    return op ? ((a[63] != b[63]) && (r[63] != a[63])) : ((a[63] == b[63]) && (r[63] != a[63]));
  endfunction

  logic [2:0]  apipe = '0;
  logic [63:0] m_res = '0;
  logic        m_ovf = 1'b0;
  logic        force_ready = 1'b0;

  always @(posedge CLK) begin
    apipe <= {apipe[1:0], ADDER_START};
    if (ADDER_START) begin
      m_res <= ADDER_OPERATION ? ADDER_DATA_A_IN - ADDER_DATA_B_IN : ADDER_DATA_A_IN + ADDER_DATA_B_IN;
      m_ovf <= ovf_f(ADDER_OPERATION, ADDER_DATA_A_IN, ADDER_DATA_B_IN);
    end
  end

  assign ADDER_READY        = apipe[2] | force_ready;
  assign ADDER_DATA_OUT     = m_res;
  assign ADDER_OVERFLOW_OUT = m_ovf;

  typedef struct {
    logic [3:0]  rdy;
    logic [1:0]  gi;
    logic [63:0] d;
    logic        o;
  } comp_t;

  comp_t comp_q[$];
  comp_t mon_c;
  int    n_astart = 0;

  always @(posedge CLK) begin
    if (ADDER_START) n_astart <= n_astart + 1;
    if (|REQ_READY) begin
      mon_c.rdy = REQ_READY;
      mon_c.gi  = GRANT_INDEX;
      mon_c.d   = REQ_DATA_OUT;
      mon_c.o   = REQ_OVERFLOW_OUT;
      comp_q.push_back(mon_c);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_comp(input int target, input int budget);
    int c;
    c = 0;
    while (comp_q.size() < target && c < budget) begin
      @(negedge CLK);
      c++;
    end
    if (comp_q.size() < target) chk("completion_timeout", 64'(comp_q.size()), 64'(target));
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge CLK); REQ_START = m;
    @(negedge CLK); REQ_START = '0;
  endtask

  typedef struct {
    logic [1:0]  idx;
    logic        op;
    logic [63:0] a, b, exp;
    logic        ovf;
  } vec_t;

  vec_t vt[6];
  int   base, s0, s1, rearms, cyc;
  int   order_exp[4];
  logic [63:0] data_exp[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'd2, 1'b0, 64'd5, 64'd3, 64'd8, 1'b0};
    vt[1] = '{2'd0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1};
    vt[2] = '{2'd3, 1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[3] = '{2'd1, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    vt[4] = '{2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0};
    vt[5] = '{2'd1, 1'b1, 64'd10, 64'd4, 64'd6, 1'b0};

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_ctrl", 64'({REQ_READY, GRANT_INDEX, BUSY, ADDER_START, ADDER_OPERATION, REQ_OVERFLOW_OUT}), 64'd0);
    chk("rst_data", REQ_DATA_OUT | ADDER_DATA_A_IN | ADDER_DATA_B_IN, 64'd0);
    RST = 1'b0;

    // Single-requester vectors
    for (int v = 0; v < 6; v++) begin
      base = comp_q.size();
      s0   = n_astart;
      @(negedge CLK);
      REQ_OPERATION[vt[v].idx] = vt[v].op;
      REQ_DATA_A_IN[vt[v].idx] = vt[v].a;
      REQ_DATA_B_IN[vt[v].idx] = vt[v].b;
      REQ_START = 4'b0001 << vt[v].idx;
      @(negedge CLK); REQ_START = '0;
      @(negedge CLK);
      chk("v_adder_start", 64'(ADDER_START), 64'd1);
      chk("v_busy", 64'(BUSY), 64'd1);
      chk("v_grant", 64'(GRANT_INDEX), 64'(vt[v].idx));
      chk("v_adder_a", ADDER_DATA_A_IN, vt[v].a);
      wait_comp(base + 1, 30);
      if (comp_q.size() > base) begin
        chk("v_ready", 64'(comp_q[base].rdy), 64'(4'b0001 << vt[v].idx));
        chk("v_data", comp_q[base].d, vt[v].exp);
        chk("v_ovf", 64'(comp_q[base].o), 64'(vt[v].ovf));
      end
      chk("v_busy_after", 64'(BUSY), 64'd0);
      chk("v_start_count", 64'(n_astart - s0), 64'd1);
    end

    // All four at once after reset: served 0,1,2,3
    do_reset();
    REQ_OPERATION = 4'b0010;
    REQ_DATA_A_IN[0] = 64'd1;   REQ_DATA_B_IN[0] = 64'd2;
    REQ_DATA_A_IN[1] = 64'd10;  REQ_DATA_B_IN[1] = 64'd4;
    REQ_DATA_A_IN[2] = 64'd100; REQ_DATA_B_IN[2] = 64'd200;
    REQ_DATA_A_IN[3] = 64'hFFFF_FFFF_FFFF_FFFF; REQ_DATA_B_IN[3] = 64'd2;
    data_exp = '{64'd3, 64'd6, 64'd300, 64'd1};
    base = comp_q.size();
    pulse(4'b1111);
    wait_comp(base + 4, 100);
    for (int k = 0; k < 4; k++) begin
      if (comp_q.size() > base + k) begin
        chk("all4_order", 64'(comp_q[base + k].gi), 64'(k));
        chk("all4_data", comp_q[base + k].d, data_exp[k]);
      end
    end

    // Req 0 and 3 re-armed on their first two completions
    do_reset();
    REQ_OPERATION = '0;
    REQ_DATA_A_IN[0] = 64'd1; REQ_DATA_B_IN[0] = 64'd1;
    REQ_DATA_A_IN[3] = 64'd2; REQ_DATA_B_IN[3] = 64'd2;
`ifdef ACCELERATOR_ADDER_ARBITER_FIXED_PRIORITY_EN
    order_exp = '{0, 0, 0, 3};
`else
    order_exp = '{0, 3, 0, 3};
`endif
    base = comp_q.size();
    rearms = 0;
    pulse(4'b1001);
    cyc = 0;
    while (comp_q.size() < base + 4 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (ADDER_READY && rearms < 2) begin
        REQ_START = 4'b0001 << GRANT_INDEX;
        rearms++;
      end else begin
        REQ_START = '0;
      end
    end
    REQ_START = '0;
    wait_comp(base + 4, 1);
    for (int k = 0; k < 4; k++)
      if (comp_q.size() > base + k)
        chk("rearm_order", 64'(comp_q[base + k].gi), 64'(order_exp[k]));
    repeat (20) @(negedge CLK);
    chk("rearm_no_extra", 64'(comp_q.size() - base), 64'd4);

    // Req 1: start while pending is absorbed; start in its READY cycle re-arms
    base = comp_q.size();
    s0   = n_astart;
    pulse(4'b0010);
    pulse(4'b0010);
    cyc = 0;
    while (!ADDER_READY && cyc < 30) begin
      @(negedge CLK);
      cyc++;
    end
    chk("req1_adder_ready_seen", 64'(ADDER_READY), 64'd1);
    REQ_START = 4'b0010;
    @(negedge CLK); REQ_START = '0;
    wait_comp(base + 2, 40);
    repeat (20) @(negedge CLK);
    chk("req1_services", 64'(comp_q.size() - base), 64'd2);
    chk("req1_start_count", 64'(n_astart - s0), 64'd2);
    if (comp_q.size() > base + 1) begin
      chk("req1_ready_a", 64'(comp_q[base].rdy), 64'b0010);
      chk("req1_ready_b", 64'(comp_q[base + 1].rdy), 64'b0010);
    end

    // Reset while waiting on the adder
    base = comp_q.size();
    pulse(4'b0100);
    @(negedge CLK);
    chk("midrst_busy_before", 64'(BUSY), 64'd1);
    @(negedge CLK); RST = 1'b1;
    #1;
    chk("midrst_ctrl", 64'({REQ_READY, GRANT_INDEX, BUSY, ADDER_START, ADDER_OPERATION, REQ_OVERFLOW_OUT}), 64'd0);
    chk("midrst_data", REQ_DATA_OUT | ADDER_DATA_A_IN | ADDER_DATA_B_IN, 64'd0);
    @(negedge CLK); RST = 1'b0;
    s1 = n_astart;
    repeat (4) @(negedge CLK);
    force_ready = 1'b1;
    @(negedge CLK); force_ready = 1'b0;
    repeat (15) @(negedge CLK);
    chk("midrst_no_ready", 64'(comp_q.size() - base), 64'd0);
    chk("midrst_no_regrant", 64'(n_astart - s1), 64'd0);
    chk("midrst_busy_after", 64'(BUSY), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
